// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU datapath: accepts one command, drives the
// operands for SETTLE cycles, captures the result and holds it until the consumer takes it.
module alu_issue_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [5:0] cmd_a,
    input  logic [5:0] cmd_b,
    input  logic [3:0] cmd_sel,
    output logic [5:0] alu_a,
    output logic [5:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [5:0] alu_x,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [5:0] rsp_x,
    output logic [3:0] rsp_sel,
    output logic [7:0] op_cnt
);

    // Handshakes: a transfer happens on a rising edge where both valid and ready are high;
    // valid-side data is held stable from valid rising until that edge.

    // A zero settle time would sample before the operands reach the ALU, so it is treated as 1.
    localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
    localparam logic [3:0]  WAIT_LOAD  = 4'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_WAIT,
        RESP
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            alu_a     <= 6'd0;
            alu_b     <= 6'd0;
            alu_sel   <= 4'd0;
            rsp_x     <= 6'd0;
            rsp_sel   <= 4'd0;
            op_cnt    <= 8'd0;
            wait_cnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_a     <= cmd_a;
                        alu_b     <= cmd_b;
                        alu_sel   <= cmd_sel;
                        wait_cnt  <= WAIT_LOAD;
                        cmd_ready <= 1'b0;
                        state     <= SETTLE_WAIT;
                    end else begin
                        // Covers the first edge after reset release as well.
                        cmd_ready <= 1'b1;
                    end
                end
                SETTLE_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        rsp_x     <= alu_x;
                        rsp_sel   <= alu_sel;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_cnt    <= op_cnt + 8'd1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: random commands against a bench-side ALU model and a
// transaction-level expectation of latency, spacing, hold behaviour and completion count.
module tb_alu_issue_ctrl;

    localparam int SET = 2;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [9:0] exp_q[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       rsp_ready = 1'b0;
    logic [5:0] cmd_a = 6'd0;
    logic [5:0] cmd_b = 6'd0;
    logic [3:0] cmd_sel = 4'd0;

    // Main instance (combinational ALU model)
    logic       cmd_ready, rsp_valid;
    logic [5:0] alu_a, alu_b, alu_x, rsp_x;
    logic [3:0] alu_sel, rsp_sel;
    logic [7:0] op_cnt;

    // Three instances fed by an ALU model whose result lags its operands by one cycle
    logic       v2 = 1'b0;
    logic       rr2 = 1'b0;
    logic       cr_s2, cr_s1, cr_s0, rv_s2, rv_s1, rv_s0;
    logic [5:0] aa_s2, aa_s1, aa_s0, ab_s2, ab_s1, ab_s0;
    logic [3:0] as_s2, as_s1, as_s0, rs_s2, rs_s1, rs_s0;
    logic [5:0] ax_s2, ax_s1, ax_s0, rx_s2, rx_s1, rx_s0;
    logic [7:0] oc_s2, oc_s1, oc_s0;

    function automatic logic [5:0] alu_f(input logic [5:0] a, input logic [5:0] b, input logic [3:0] s);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~b;
            4'd9:    return ~a;
            default: return a + b + {2'b00, s};
        endcase
    endfunction

    assign alu_x = alu_f(alu_a, alu_b, alu_sel);

    always @(posedge clk) begin
        ax_s2 <= alu_f(aa_s2, ab_s2, as_s2);
        ax_s1 <= alu_f(aa_s1, ab_s1, as_s1);
        ax_s0 <= alu_f(aa_s0, ab_s0, as_s0);
    end

    always #5 clk = ~clk;

    alu_issue_ctrl #(.SETTLE(SET)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_x(alu_x),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_x(rsp_x), .rsp_sel(rsp_sel),
        .op_cnt(op_cnt)
    );

    alu_issue_ctrl #(.SETTLE(2)) dut_s2 (
        .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_ready(cr_s2),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(aa_s2), .alu_b(ab_s2), .alu_sel(as_s2), .alu_x(ax_s2),
        .rsp_valid(rv_s2), .rsp_ready(rr2), .rsp_x(rx_s2), .rsp_sel(rs_s2),
        .op_cnt(oc_s2)
    );

    alu_issue_ctrl #(.SETTLE(1)) dut_s1 (
        .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_ready(cr_s1),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(aa_s1), .alu_b(ab_s1), .alu_sel(as_s1), .alu_x(ax_s1),
        .rsp_valid(rv_s1), .rsp_ready(rr2), .rsp_x(rx_s1), .rsp_sel(rs_s1),
        .op_cnt(oc_s1)
    );

    alu_issue_ctrl #(.SETTLE(0)) dut_s0 (
        .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_ready(cr_s0),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(aa_s0), .alu_b(ab_s0), .alu_sel(as_s0), .alu_x(ax_s0),
        .rsp_valid(rv_s0), .rsp_ready(rr2), .rsp_x(rx_s0), .rsp_sel(rs_s0),
        .op_cnt(oc_s0)
    );

    task automatic wait_main_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL wait_ready: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
        end
    endtask

    task automatic test_reset();
        logic [41:0] obs;
        #1;
        obs = {cmd_ready, rsp_valid, alu_a, alu_b, alu_sel, rsp_x, rsp_sel, op_cnt};
        total++;
        if (obs !== 42'd0) begin bad++; $display("FAIL reset_async: outputs=%h required 0", obs); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_release_early: cmd_ready=%b required 0", cmd_ready); end
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_first_edge: cmd_ready=%b required 1", cmd_ready); end
        exp_cnt = 8'd0;
    endtask

    task automatic test_basic();
        logic [5:0] b;
        wait_main_ready();
        b = 6'($urandom_range(0, 63));
        cmd_a = 6'b000101; cmd_b = b; cmd_sel = 4'b1001;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;   // held high while settling: must not matter
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a = 6'($urandom_range(0, 63)); cmd_sel = 4'($urandom_range(0, 15));
        total++;
        if ({alu_a, alu_b, alu_sel} !== {6'b000101, b, 4'b1001}) begin
            bad++; $display("FAIL basic_drive: alu=%h required %h", {alu_a, alu_b, alu_sel}, {6'b000101, b, 4'b1001});
        end
        total++;
        if ({cmd_ready, rsp_valid} !== 2'b00) begin bad++; $display("FAIL basic_busy: ready/valid=%b required 00", {cmd_ready, rsp_valid}); end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_early: rsp_valid=%b required 0", rsp_valid); end
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_x, rsp_sel} !== {1'b1, 6'b111010, 4'b1001}) begin
            bad++; $display("FAIL basic_rsp: v/x/sel=%b/%b/%b required 1/111010/1001", rsp_valid, rsp_x, rsp_sel);
        end
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        total++;
        if ({rsp_valid, cmd_ready, op_cnt} !== {1'b0, 1'b1, exp_cnt}) begin
            bad++; $display("FAIL basic_done: v/ready/cnt=%b/%b/%0d required 0/1/%0d", rsp_valid, cmd_ready, op_cnt, exp_cnt);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_hold();
        int n = 0;
        logic [5:0] a;
        wait_main_ready();
        a = 6'($urandom_range(0, 63));
        cmd_a = a; cmd_b = 6'b110000; cmd_sel = 4'b0101;
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({rsp_valid, rsp_x, rsp_sel, cmd_ready} !== {1'b1, 6'b001111, 4'b0101, 1'b0}) begin
                bad++; $display("FAIL hold_%0d: v/x/sel/ready=%b/%b/%b/%b required 1/001111/0101/0", i, rsp_valid, rsp_x, rsp_sel, cmd_ready);
            end
            total++;
            if ({alu_a, alu_b, alu_sel} !== {a, 6'b110000, 4'b0101}) begin
                bad++; $display("FAIL hold_alu_%0d: alu=%h required %h", i, {alu_a, alu_b, alu_sel}, {a, 6'b110000, 4'b0101});
            end
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a = 6'($urandom_range(0, 63)); cmd_b = 6'($urandom_range(0, 63)); cmd_sel = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        total++;
        if ({rsp_valid, cmd_ready, op_cnt} !== {1'b0, 1'b1, exp_cnt}) begin
            bad++; $display("FAIL hold_done: v/ready/cnt=%b/%b/%0d required 0/1/%0d", rsp_valid, cmd_ready, op_cnt, exp_cnt);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [41:0] obs;
        wait_main_ready();
        cmd_a = 6'($urandom_range(1, 63)); cmd_b = 6'($urandom_range(1, 63)); cmd_sel = 4'($urandom_range(1, 15));
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        obs = {cmd_ready, rsp_valid, alu_a, alu_b, alu_sel, rsp_x, rsp_sel, op_cnt};
        total++;
        if (obs !== 42'd0) begin bad++; $display("FAIL midrst_async: outputs=%h required 0", obs); end
        @(negedge clk);
        #2 rst = 1'b0;
        exp_cnt = 8'd0;
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL midrst_release: cmd_ready=%b required 0", cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, cmd_ready, op_cnt} !== {1'b0, 1'b1, 8'd0}) begin
                bad++; $display("FAIL midrst_after_%0d: v/ready/cnt=%b/%b/%0d required 0/1/0", i, rsp_valid, cmd_ready, op_cnt);
            end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_settle_delay();
        logic [5:0] pa = 6'd0, pb = 6'd0, ca, cb;
        logic [3:0] ps = 4'd0, cs;
        logic [5:0] stale, fresh;
        rr2 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            total++;
            if ({cr_s2, cr_s1, cr_s0} !== 3'b111) begin bad++; $display("FAIL settle_ready_%0d: ready=%b required 111", k, {cr_s2, cr_s1, cr_s0}); end
            stale = alu_f(pa, pb, ps);
            do begin
                ca = 6'($urandom_range(0, 63)); cb = 6'($urandom_range(0, 63)); cs = 4'($urandom_range(0, 15));
                fresh = alu_f(ca, cb, cs);
            end while (fresh == stale);
            cmd_a = ca; cmd_b = cb; cmd_sel = cs;
            v2 = 1'b1;
            @(negedge clk);
            v2 = 1'b0;
            @(negedge clk);
            // One settle cycle samples before the lagging result arrives.
            total++;
            if ({rv_s1, rx_s1, rv_s0, rx_s0} !== {1'b1, stale, 1'b1, stale}) begin
                bad++; $display("FAIL settle_short_%0d: s1 v/x=%b/%h s0 v/x=%b/%h required 1/%h", k, rv_s1, rx_s1, rv_s0, rx_s0, stale);
            end
            total++;
            if (rv_s2 !== 1'b0) begin bad++; $display("FAIL settle2_early_%0d: rsp_valid=%b required 0", k, rv_s2); end
            @(negedge clk);
            total++;
            if ({rv_s2, rx_s2, rs_s2} !== {1'b1, fresh, cs}) begin
                bad++; $display("FAIL settle2_%0d: v/x/sel=%b/%h/%h required 1/%h/%h", k, rv_s2, rx_s2, rs_s2, fresh, cs);
            end
            @(negedge clk);
            pa = ca; pb = cb; ps = cs;
        end
        total++;
        if ({oc_s2, oc_s1, oc_s0} !== {8'd6, 8'd6, 8'd6}) begin
            bad++; $display("FAIL settle_count: cnt=%0d/%0d/%0d required 6", oc_s2, oc_s1, oc_s0);
        end
        rr2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n_iss = 0, n_rsp = 0, cyc = 0, last_acc = -1, acc;
        int acc_q[$];
        logic [9:0] e;
        exp_q.delete();
        wait_main_ready();
        rsp_ready = 1'b1;
        while (n_rsp < 257 && cyc < 257 * 8 + 50) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra: unexpected response x=%h", rsp_x);
                end else begin
                    e = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    if ({rsp_sel, rsp_x} !== e) begin
                        bad++; $display("FAIL b2b_data_%0d: sel/x=%h required %h", n_rsp, {rsp_sel, rsp_x}, e);
                    end
                    total++;
                    if (cyc != acc + SET + 1) begin
                        bad++; $display("FAIL b2b_latency_%0d: cycle=%0d required %0d", n_rsp, cyc, acc + SET + 1);
                    end
                    total++;
                    if (op_cnt !== exp_cnt) begin
                        bad++; $display("FAIL b2b_count_%0d: op_cnt=%0d required %0d", n_rsp, op_cnt, exp_cnt);
                    end
                    exp_cnt = exp_cnt + 8'd1;
                    n_rsp++;
                end
            end
            if (cmd_ready === 1'b1 && n_iss < 257) begin
                if (last_acc >= 0) begin
                    total++;
                    if (cyc - last_acc != SET + 2) begin
                        bad++; $display("FAIL b2b_spacing_%0d: spacing=%0d required %0d", n_iss, cyc - last_acc, SET + 2);
                    end
                end
                last_acc = cyc;
                cmd_a = 6'($urandom_range(0, 63)); cmd_b = 6'($urandom_range(0, 63)); cmd_sel = 4'($urandom_range(0, 15));
                cmd_valid = 1'b1;
                exp_q.push_back({cmd_sel, alu_f(cmd_a, cmd_b, cmd_sel)});
                acc_q.push_back(cyc);
                n_iss++;
            end else begin
                cmd_valid = (n_iss < 257) ? 1'($urandom_range(0, 1)) : 1'b0;
                cmd_a = 6'($urandom_range(0, 63)); cmd_b = 6'($urandom_range(0, 63)); cmd_sel = 4'($urandom_range(0, 15));
            end
        end
        cmd_valid = 1'b0;
        total++;
        if (n_rsp != 257) begin bad++; $display("FAIL b2b_timeout: responses=%0d required 257", n_rsp); end
        @(negedge clk);
        total++;
        if (op_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_final_count: op_cnt=%0d required %0d", op_cnt, exp_cnt); end
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid();
        test_settle_delay();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
